store_drain_scheduler: RTL and testbench

Sequences committed stores out of the store buffer into the single data-memory port and shares that port with the load pipeline. Retirement pushes the store-buffer entry index of each committed store. The block arbitrates between pending loads and committed-store drains, reads the entry's address, data and mask, and issues the memory write. On acceptance it returns the entry index to the store-buffer free list over `retire_store_valid`/`retire_entry`.

---
 rtl/store_drain_scheduler_pkg.sv | 18 +
 rtl/store_drain_scheduler_if.sv | 37 +++
 rtl/store_drain_scheduler_commit_idx_fifo.sv | 67 ++++++
 rtl/store_drain_scheduler.sv | 174 +++++++++++++++++
 tb/tb_store_drain_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_drain_scheduler_pkg.sv
// Shared types and constants for the store drain scheduler.
package store_drain_pkg;

    // Arbitration/issue state of the single data-memory port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } drain_state_e;

    localparam int unsigned BYTE_BITS = 8;

    // Byte-enable width for a given data width.
    function automatic int unsigned mask_width(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/store_drain_scheduler_if.sv
// Data-memory request bus shared by loads and store drains.
interface store_drain_scheduler_if
    import store_drain_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned MASK_WIDTH = mask_width(DATA_WIDTH);

    logic                  mem_req_valid;
    logic                  mem_req_we;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [MASK_WIDTH-1:0] mem_req_wmask;
    logic                  mem_req_ready;

    // Requester side (the scheduler).
    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        output mem_req_wmask,
        input  mem_req_ready
    );

    // Memory side.
    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        input  mem_req_wmask,
        output mem_req_ready
    );

endinterface

// File: rtl/store_drain_scheduler_commit_idx_fifo.sv
// FIFO of committed store-buffer indices, in commit order.
module commit_idx_fifo
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned IDX   = $clog2(DEPTH),
    localparam int unsigned CNT   = IDX + 1
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [IDX-1:0] push_idx,
    input  logic           pop,
    output logic [IDX-1:0] head_idx,
    output logic [CNT-1:0] count,
    output logic           full
);

    localparam logic [CNT-1:0] DEPTH_C = CNT'(DEPTH);
    localparam logic [IDX-1:0] LAST_C  = IDX'(DEPTH - 1);

    logic [IDX-1:0] slots [DEPTH];
    logic [IDX-1:0] head_q;
    logic [IDX-1:0] tail_q;
    logic [CNT-1:0] count_q;
    logic           do_push;
    logic           do_pop;

    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign head_idx = slots[head_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && (count_q != '0);

    // Slot storage; cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (do_push) begin
            slots[tail_q] <= push_idx;
        end
    end

    // Head/tail pointers wrapping modulo DEPTH, and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= (tail_q == LAST_C) ? '0 : tail_q + 1'b1;
            end
            if (do_pop) begin
                head_q <= (head_q == LAST_C) ? '0 : head_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/store_drain_scheduler.sv
// Drains committed stores into the shared data-memory port, arbitrating
// against loads with a high-watermark and a starvation limit.
module store_drain_scheduler
    import store_drain_pkg::*;
#(
    parameter  int unsigned SB_DEPTH     = 16,
    parameter  int unsigned ADDR_WIDTH   = 32,
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned HIGH_WM      = 12,
    parameter  int unsigned STARVE_LIMIT = 8,
    localparam int unsigned IDX          = $clog2(SB_DEPTH),
    localparam int unsigned CNT          = IDX + 1,
    localparam int unsigned MASK_WIDTH   = mask_width(DATA_WIDTH)
)
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  commit_valid,
    input  logic [IDX-1:0]        commit_entry,
    output logic                  commit_ready,

    output logic [IDX-1:0]        rd_entry,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [MASK_WIDTH-1:0] rd_mask,

    input  logic                  load_req_valid,
    input  logic [ADDR_WIDTH-1:0] load_req_addr,
    output logic                  load_req_ready,

    store_drain_scheduler_if.master mem,

    output logic                  retire_store_valid,
    output logic [IDX-1:0]        retire_entry,
    output logic [CNT-1:0]        pending_count,
    output logic                  sb_quiescent
);

    localparam logic [CNT-1:0] HIGH_WM_C = CNT'(HIGH_WM);
    localparam logic [CNT-1:0] STARVE_C  = CNT'(STARVE_LIMIT);

    drain_state_e          state_q;
    drain_state_e          state_d;
    logic [CNT-1:0]        count;
    logic                  full;
    logic [IDX-1:0]        head_idx;
    logic                  push;
    logic                  pop;
    logic                  grant_store;
    logic                  grant_load;
    logic                  force_drain;
    logic [CNT-1:0]        starve_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [MASK_WIDTH-1:0] mask_q;
    logic                  retire_valid_q;
    logic [IDX-1:0]        retire_entry_q;

    assign commit_ready = !full;
    assign push         = commit_valid && commit_ready;

    commit_idx_fifo #(
        .DEPTH (SB_DEPTH)
    ) u_commit_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_idx (commit_entry),
        .pop      (pop),
        .head_idx (head_idx),
        .count    (count),
        .full     (full)
    );

    assign rd_entry    = head_idx;
    assign force_drain = (count >= HIGH_WM_C) || (starve_q >= STARVE_C);

    // The in-flight store stays at the queue head until memory accepts it,
    // so the queue count alone already covers it.
    assign pending_count = count;
    assign sb_quiescent  = (count == '0) && (state_q != ST_STORE);

    assign mem.mem_req_valid = (state_q != ST_IDLE);
    assign mem.mem_req_we    = (state_q == ST_STORE);
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_req_wdata = data_q;
    assign mem.mem_req_wmask = mask_q;

    assign retire_store_valid = retire_valid_q;
    assign retire_entry       = retire_entry_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration in IDLE, completion in LOAD/STORE.
    always_comb begin
        state_d        = state_q;
        load_req_ready = 1'b0;
        grant_store    = 1'b0;
        grant_load     = 1'b0;
        pop            = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if ((count != '0) && (force_drain || !load_req_valid)) begin
                    grant_store = 1'b1;
                    state_d     = ST_STORE;
                end else if (load_req_valid) begin
                    grant_load     = 1'b1;
                    load_req_ready = 1'b1;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (mem.mem_req_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STORE: begin
                if (mem.mem_req_ready) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request field capture at grant; held stable until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else if (grant_store) begin
            addr_q <= rd_addr;
            data_q <= rd_data;
            mask_q <= rd_mask;
        end else if (grant_load) begin
            addr_q <= load_req_addr;
            data_q <= '0;
            mask_q <= '0;
        end
    end

    // Saturating count of load grants taken while stores wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (grant_store) begin
            starve_q <= '0;
        end else if (grant_load && (count != '0) && (starve_q != '1)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // One-cycle free-list return of the entry memory just accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid_q <= 1'b0;
            retire_entry_q <= '0;
        end else begin
            retire_valid_q <= pop;
            retire_entry_q <= pop ? head_idx : '0;
        end
    end

endmodule

// File: tb/tb_store_drain_scheduler.sv
// Self-checking bench for store_drain_scheduler against a queue-based model.
module tb_store_drain_scheduler;
    localparam int SB_DEPTH = 16;
    localparam int IDX      = 4;
    localparam int CNT      = 5;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MW       = 4;
    localparam int HIGH_WM  = 12;
    localparam int STARVE   = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           commit_valid;
    logic [IDX-1:0] commit_entry;
    logic           commit_ready;
    logic [IDX-1:0] rd_entry;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic [MW-1:0]  rd_mask;
    logic           load_req_valid;
    logic [AW-1:0]  load_req_addr;
    logic           load_req_ready;
    logic           retire_store_valid;
    logic [IDX-1:0] retire_entry;
    logic [CNT-1:0] pending_count;
    logic           sb_quiescent;

    logic [AW-1:0] sb_addr [SB_DEPTH];
    logic [DW-1:0] sb_data [SB_DEPTH];
    logic [MW-1:0] sb_mask [SB_DEPTH];

    always #5 clk = ~clk;

    store_drain_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    assign rd_addr = sb_addr[rd_entry];
    assign rd_data = sb_data[rd_entry];
    assign rd_mask = sb_mask[rd_entry];

    store_drain_scheduler #(
        .SB_DEPTH     (SB_DEPTH),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .HIGH_WM      (HIGH_WM),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .commit_valid       (commit_valid),
        .commit_entry       (commit_entry),
        .commit_ready       (commit_ready),
        .rd_entry           (rd_entry),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .rd_mask            (rd_mask),
        .load_req_valid     (load_req_valid),
        .load_req_addr      (load_req_addr),
        .load_req_ready     (load_req_ready),
        .mem                (mem_bus),
        .retire_store_valid (retire_store_valid),
        .retire_entry       (retire_entry),
        .pending_count      (pending_count),
        .sb_quiescent       (sb_quiescent)
    );

    // Reference model: committed indices in order, plus the one request
    // currently offered to memory (0 none, 1 load, 2 store).
    int            q[$];
    int            req_kind;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    int            starve;
    bit            ret_p;
    int            ret_idx;

    int n_checks = 0;
    int n_fail   = 0;

    bit obs_lr, obs_valid, obs_we, obs_ret, obs_cr;
    int next_idx = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        req_kind = 0;
        m_addr   = '0;
        m_data   = '0;
        m_mask   = '0;
        starve   = 0;
        ret_p    = 0;
        ret_idx  = 0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model and clock.
    task automatic cycle();
        int sz;
        bit force_d, sg, lg;
        #3;
        sz = q.size();
        obs_lr    = load_req_ready;
        obs_valid = mem_bus.mem_req_valid;
        obs_we    = mem_bus.mem_req_we;
        obs_ret   = retire_store_valid;
        obs_cr    = commit_ready;
        check("commit_ready", commit_ready, sz != SB_DEPTH);
        if (sz > 0) check("rd_entry", rd_entry, q[0]);
        check("pending_count", pending_count, sz);
        check("sb_quiescent", sb_quiescent, (sz == 0) && (req_kind != 2));
        check("retire_valid", retire_store_valid, ret_p);
        check("retire_entry", retire_entry, ret_p ? ret_idx : 0);
        check("mem_valid", mem_bus.mem_req_valid, req_kind != 0);
        if (req_kind != 0) begin
            check("mem_we", mem_bus.mem_req_we, req_kind == 2);
            check("mem_addr", mem_bus.mem_req_addr, m_addr);
            check("mem_wdata", mem_bus.mem_req_wdata, m_data);
            check("mem_wmask", mem_bus.mem_req_wmask, m_mask);
        end
        sg = 0;
        lg = 0;
        if (req_kind == 0) begin
            force_d = (sz >= HIGH_WM) || (starve >= STARVE);
            sg = (sz > 0) && (force_d || !load_req_valid);
            lg = !sg && load_req_valid;
        end
        check("load_ready", load_req_ready, lg);

        ret_p = 0;
        if (req_kind != 0) begin
            if (mem_bus.mem_req_ready) begin
                if (req_kind == 2) begin
                    ret_p   = 1;
                    ret_idx = q.pop_front();
                end
                req_kind = 0;
            end
        end else if (sg) begin
            req_kind = 2;
            m_addr   = sb_addr[q[0]];
            m_data   = sb_data[q[0]];
            m_mask   = sb_mask[q[0]];
            starve   = 0;
        end else if (lg) begin
            req_kind = 1;
            m_addr   = load_req_addr;
            m_data   = '0;
            m_mask   = '0;
            if (sz > 0 && starve < 31) starve++;
        end
        if (commit_valid && sz != SB_DEPTH) q.push_back(int'(commit_entry));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (!(sb_quiescent === 1'b1 && mem_bus.mem_req_valid === 1'b0) && k < 200) begin
            cycle();
            k++;
        end
        check("drain_quiescent", {sb_quiescent, mem_bus.mem_req_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int lg_cnt, st_cnt;
        bit seen;
        for (int i = 0; i < SB_DEPTH; i++) begin
            sb_addr[i] = $urandom;
            sb_data[i] = $urandom;
            sb_mask[i] = MW'($urandom);
        end
        sb_addr[5] = 32'h100;
        sb_data[5] = 32'hDEADBEEF;
        sb_mask[5] = 4'hF;

        rst            = 1'b1;
        commit_valid   = 1'b0;
        commit_entry   = '0;
        load_req_valid = 1'b0;
        load_req_addr  = '0;
        mem_bus.mem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_commit_ready", commit_ready, 1);
        check("rst_quiescent", sb_quiescent, 1);
        check("rst_rd_entry", rd_entry, 0);
        check("rst_mem_valid", mem_bus.mem_req_valid, 0);
        check("rst_mem_we", mem_bus.mem_req_we, 0);
        check("rst_mem_addr", mem_bus.mem_req_addr, 0);
        check("rst_load_ready", load_req_ready, 0);
        check("rst_retire", {retire_store_valid, retire_entry}, 0);
        check("rst_pending", pending_count, 0);
        rst = 1'b0;
        model_reset();

        // Idle.
        repeat (5) cycle();

        // Single store to entry 5.
        mem_bus.mem_req_ready = 1'b1;
        commit_valid = 1'b1;
        commit_entry = 4'd5;
        cycle();
        commit_valid = 1'b0;
        cycle();
        check("single_valid_at_c2", {mem_bus.mem_req_valid, mem_bus.mem_req_we}, 2'b11);
        check("single_addr", mem_bus.mem_req_addr, 32'h100);
        check("single_data", mem_bus.mem_req_wdata, 32'hDEADBEEF);
        cycle();
        check("single_retire", {retire_store_valid, retire_entry}, 5'h15);
        repeat (2) cycle();

        // Back-pressure on a store.
        mem_bus.mem_req_ready = 1'b0;
        commit_valid = 1'b1;
        commit_entry = 4'd7;
        cycle();
        commit_valid = 1'b0;
        repeat (5) cycle();
        check("bp_pending", pending_count, 1);
        check("bp_valid", mem_bus.mem_req_valid, 1);
        mem_bus.mem_req_ready = 1'b1;
        repeat (3) cycle();

        // Starvation: one store against continuous loads.
        load_req_valid = 1'b1;
        repeat (3) begin
            load_req_addr = $urandom;
            cycle();
        end
        commit_valid = 1'b1;
        commit_entry = 4'd3;
        load_req_addr = $urandom;
        cycle();
        commit_valid = 1'b0;
        lg_cnt = 0;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            load_req_addr = $urandom;
            cycle();
            if (obs_valid && obs_we) seen = 1;
            else if (obs_lr) lg_cnt++;
        end
        check("starve_store_seen", seen, 1);
        check("starve_load_grants", lg_cnt, STARVE);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            load_req_addr = $urandom;
            cycle();
            if (obs_lr) seen = 1;
        end
        check("starve_loads_resume", seen, 1);
        load_req_valid = 1'b0;
        drain();

        // High watermark: 14 commits queued behind a stalled load.
        load_req_valid = 1'b1;
        load_req_addr  = $urandom;
        mem_bus.mem_req_ready = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 14; i++) begin
            commit_valid = 1'b1;
            commit_entry = IDX'(next_idx);
            next_idx++;
            cycle();
        end
        commit_valid = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        st_cnt = 0;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            load_req_addr = $urandom;
            cycle();
            if (obs_ret) st_cnt++;
            if (obs_lr) seen = 1;
        end
        check("hwm_load_seen", seen, 1);
        check("hwm_stores_before_load", st_cnt, 3);
        load_req_valid = 1'b0;
        drain();

        // Fill to full, drain with commits pressing, refill across wrap.
        mem_bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            commit_valid = 1'b1;
            commit_entry = IDX'(next_idx);
            cycle();
            if (obs_cr) next_idx++;
        end
        check("full_ready", commit_ready, 0);
        check("full_pending", pending_count, SB_DEPTH);
        mem_bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            commit_entry = IDX'(next_idx);
            cycle();
            if (obs_cr) next_idx++;
        end
        commit_valid = 1'b0;
        drain();
        mem_bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            commit_valid = 1'b1;
            commit_entry = IDX'(next_idx);
            next_idx++;
            cycle();
        end
        commit_valid = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        drain();
        check("wrap_pending_zero", pending_count, 0);

        // Reset while a store request is outstanding.
        mem_bus.mem_req_ready = 1'b0;
        commit_valid = 1'b1;
        commit_entry = 4'd9;
        cycle();
        commit_valid = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        #1;
        check("midrst_valid", mem_bus.mem_req_valid, 0);
        check("midrst_pending", pending_count, 0);
        check("midrst_commit_ready", commit_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            commit_valid   = ($urandom_range(0, 2) != 0);
            commit_entry   = IDX'($urandom);
            load_req_valid = ($urandom_range(0, 1) != 0);
            load_req_addr  = $urandom;
            mem_bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        commit_valid   = 1'b0;
        load_req_valid = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
